// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain driver: serialises config words LSB-first onto ccff_head
// and collects the bits leaving ccff_tail as a readback word stream.
module ccff_bitstream_loader #(
  parameter int WORD_WIDTH   = 8,
  parameter int CHAIN_LENGTH = 8,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic                  cfg_start,
  input  logic                  cfg_abort,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  ccff_head,
  output logic                  ccff_shift_en,
  input  logic                  ccff_tail,
  output logic [WORD_WIDTH-1:0] rb_data,
  output logic                  rb_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int WBW = $clog2(WORD_WIDTH) + 1;
  localparam logic [CNT_WIDTH-1:0] LAST =
    CNT_WIDTH'(CHAIN_LENGTH - 1);
  localparam logic [WBW-1:0] WLAST = WBW'(WORD_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT} state_t;

  state_t                state;
  state_t                state_n;
  logic [WORD_WIDTH-1:0] shreg;
  logic [WORD_WIDTH-1:0] rb_col;
  logic [WORD_WIDTH-1:0] rb_col_n;
  logic [WBW-1:0]        wbit;
  logic [WBW-1:0]        rb_cnt;
  logic [CNT_WIDTH-1:0]  bit_cnt;
  logic                  start_ok;
  logic                  accept;
  logic                  step;
  logic                  last_bit;
  logic                  word_end;

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    start_ok = 1'b0;
    accept   = 1'b0;
    step     = 1'b0;
    last_bit = 1'b0;
    word_end = 1'b0;
    unique case (state)
      IDLE: begin
        if (cfg_start) begin
          start_ok = 1'b1;
          state_n  = FETCH;
        end
      end
      FETCH: begin
        if (word_valid) begin
          accept  = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        step     = 1'b1;
        last_bit = (bit_cnt == LAST);
        word_end = (wbit == WLAST);
        if (last_bit)      state_n = IDLE;
        else if (word_end) state_n = FETCH;
      end
      default: state_n = IDLE;
    endcase
    // abort wins over start, acceptance and shifting
    if (cfg_abort) begin
      state_n  = IDLE;
      start_ok = 1'b0;
      accept   = 1'b0;
      step     = 1'b0;
      last_bit = 1'b0;
      word_end = 1'b0;
    end
  end

  assign word_ready = (state == FETCH);
  assign busy       = (state != IDLE);
  assign rb_col_n   = rb_col | (WORD_WIDTH'(ccff_tail) << rb_cnt);

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      ccff_shift_en <= 1'b0;
      ccff_head     <= 1'b0;
      shreg         <= '0;
      wbit          <= '0;
      bit_cnt       <= '0;
      rb_col        <= '0;
      rb_cnt        <= '0;
      rb_data       <= '0;
      rb_valid      <= 1'b0;
      done          <= 1'b0;
    end else begin
      ccff_shift_en <= (state_n == SHIFT);
      rb_valid      <= 1'b0;
      if (start_ok) begin
        done    <= 1'b0;
        bit_cnt <= '0;
        rb_col  <= '0;
        rb_cnt  <= '0;
      end
      if (accept) begin
        ccff_head <= word_data[0];
        shreg     <= word_data >> 1;
        wbit      <= '0;
      end
      if (step) begin
        ccff_head <= shreg[0];
        shreg     <= shreg >> 1;
        wbit      <= wbit + WBW'(1);
        bit_cnt   <= bit_cnt + CNT_WIDTH'(1);
        // a full word, or the zero-padded tail of the chain
        if (last_bit || rb_cnt == WLAST) begin
          rb_data  <= rb_col_n;
          rb_valid <= 1'b1;
          rb_col   <= '0;
          rb_cnt   <= '0;
        end else begin
          rb_col <= rb_col_n;
          rb_cnt <= rb_cnt + WBW'(1);
        end
        if (last_bit) done <= 1'b1;
      end
      if (cfg_abort) begin
        rb_col <= '0;
        rb_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: an 8-bit and a 12-bit chain instance,
// each driving a behavioural shift-chain, checked against expected images.
module tb_ccff_bitstream_loader;

  logic       clk;
  logic       rst;
  logic       st  [2];
  logic       ab  [2];
  logic [7:0] wd  [2];
  logic       wv  [2];
  logic       wr  [2];
  logic       hd  [2];
  logic       se  [2];
  logic       tl  [2];
  logic [7:0] rbd [2];
  logic       rbv [2];
  logic       bs  [2];
  logic       dn  [2];

  logic [11:0] chain   [2];
  logic [11:0] pre_val [2];
  logic        pre_req [2];

  bit         hb  [2][64];
  int         hn  [2];
  logic [7:0] rbw [2][8];
  int         rn  [2];
  logic [7:0] wl  [4];

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ccff_bitstream_loader #(
    .WORD_WIDTH(8), .CHAIN_LENGTH(8), .CNT_WIDTH(16)
  ) dut0 (
    .prog_clk(clk), .pReset(rst),
    .cfg_start(st[0]), .cfg_abort(ab[0]),
    .word_data(wd[0]), .word_valid(wv[0]),
    .word_ready(wr[0]), .ccff_head(hd[0]),
    .ccff_shift_en(se[0]), .ccff_tail(tl[0]),
    .rb_data(rbd[0]), .rb_valid(rbv[0]),
    .busy(bs[0]), .done(dn[0])
  );

  ccff_bitstream_loader #(
    .WORD_WIDTH(8), .CHAIN_LENGTH(12), .CNT_WIDTH(16)
  ) dut1 (
    .prog_clk(clk), .pReset(rst),
    .cfg_start(st[1]), .cfg_abort(ab[1]),
    .word_data(wd[1]), .word_valid(wv[1]),
    .word_ready(wr[1]), .ccff_head(hd[1]),
    .ccff_shift_en(se[1]), .ccff_tail(tl[1]),
    .rb_data(rbd[1]), .rb_valid(rbv[1]),
    .busy(bs[1]), .done(dn[1])
  );

  // behavioural chain: head enters bit 0, tail is the last bit
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (pre_req[i])  chain[i] <= pre_val[i];
      else if (se[i])  chain[i] <= {chain[i][10:0], hd[i]};
    end
  end
  assign tl[0] = chain[0][7];
  assign tl[1] = chain[1][11];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (se[i] === 1'b1 && hn[i] < 64) begin
        hb[i][hn[i]] = hd[i];
        hn[i]++;
      end
      if (rbv[i] === 1'b1 && rn[i] < 8) begin
        rbw[i][rn[i]] = rbd[i];
        rn[i]++;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clen(input int i);
    return (i == 1) ? 12 : 8;
  endfunction

  task automatic start_pulse(input int i);
    hn[i] = 0;
    rn[i] = 0;
    st[i] = 1'b1;
    @(negedge clk);
    st[i] = 1'b0;
  endtask

  task automatic wait_ready(input int i);
    int cyc;
    cyc = 0;
    while (wr[i] !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("fetch_wait", 32'(cyc < 50), 1);
  endtask

  // image bit k = k-th bit from the tail = k-th bit shifted in
  task automatic do_load(input int i, input int nw, input int stall,
                         input bit midst, input logic [11:0] pre);
    int         L;
    int         cyc;
    int         nrb;
    logic [11:0] pv;
    logic [11:0] expb;
    logic [11:0] gotb;
    logic [11:0] goti;
    logic [7:0]  exprb;
    L  = clen(i);
    pv = '0;
    for (int k = 0; k < L; k++) pv[L-1-k] = pre[k];
    pre_val[i] = pv;
    pre_req[i] = 1'b1;
    @(negedge clk);
    pre_req[i] = 1'b0;
    start_pulse(i);
    for (int w = 0; w < nw; w++) begin
      wait_ready(i);
      if (w > 0) begin
        for (int s = 0; s < stall; s++) begin
          chk("stall_shift_en", 32'(se[i]), 0);
          @(negedge clk);
        end
      end
      wd[i] = wl[w];
      wv[i] = 1'b1;
      @(negedge clk);
      wv[i] = 1'b0;
      wd[i] = 8'($urandom);
      if (w == 0 && midst) begin
        st[i] = 1'b1;
        @(negedge clk);
        st[i] = 1'b0;
      end
    end
    cyc = 0;
    while (dn[i] !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_wait", 32'(cyc < 100), 1);
    chk("busy_at_done", 32'(bs[i]), 0);
    chk("shift_en_at_done", 32'(se[i]), 0);
    @(negedge clk);
    chk("shift_count", 32'(hn[i]), 32'(L));
    expb = '0;
    gotb = '0;
    goti = '0;
    for (int j = 0; j < L; j++) begin
      expb[j] = wl[j/8][j%8];
      gotb[j] = hb[i][j];
      goti[j] = chain[i][L-1-j];
    end
    chk("head_bits", 32'(gotb), 32'(expb));
    chk("chain_image", 32'(goti), 32'(expb));
    nrb = (L + 7) / 8;
    chk("rb_pulses", 32'(rn[i]), 32'(nrb));
    for (int r = 0; r < nrb; r++) begin
      exprb = '0;
      for (int b = 0; b < 8; b++)
        if (r*8 + b < L) exprb[b] = pre[r*8 + b];
      chk("rb_word", 32'(rbw[i][r]), 32'(exprb));
    end
    chk("done_held", 32'(dn[i]), 1);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      st[i] = 0; ab[i] = 0; wd[i] = 0; wv[i] = 0;
      pre_req[i] = 0; pre_val[i] = 0;
      hn[i] = 0; rn[i] = 0;
    end
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++)
      chk("reset_outputs",
          32'({wr[i], hd[i], se[i], rbd[i], rbv[i], bs[i], dn[i]}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // full word with readback of the previous image
    wl[0] = 8'hA5;
    do_load(0, 1, 0, 0, 12'h03C);

    // partial last word
    wl[0] = 8'hFF;
    wl[1] = 8'h0F;
    do_load(1, 2, 0, 0, 12'($urandom));
    chk("rb_upper_zero", 32'(rbw[1][1][7:4]), 0);

    // stall between words, plus a start pulse during SHIFT
    wl[0] = 8'($urandom);
    wl[1] = 8'($urandom);
    do_load(1, 2, 5, 1, 12'($urandom));

    // abort after three shifts
    start_pulse(0);
    wait_ready(0);
    wd[0] = 8'($urandom);
    wv[0] = 1'b1;
    @(negedge clk);
    wv[0] = 1'b0;
    repeat (2) @(negedge clk);
    ab[0] = 1'b1;
    @(negedge clk);
    ab[0] = 1'b0;
    chk("abort_shift_en", 32'(se[0]), 0);
    chk("abort_busy", 32'(bs[0]), 0);
    chk("abort_done", 32'(dn[0]), 0);
    repeat (3) @(negedge clk);
    chk("abort_shifts", 32'(hn[0]), 3);
    chk("abort_no_rb", 32'(rn[0]), 0);

    // start and abort together in IDLE
    st[0] = 1'b1;
    ab[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    ab[0] = 1'b0;
    chk("start_abort_busy", 32'(bs[0]), 0);
    chk("start_abort_ready", 32'(wr[0]), 0);

    // reset in the middle of SHIFT
    start_pulse(1);
    wait_ready(1);
    wd[1] = 8'($urandom);
    wv[1] = 1'b1;
    @(negedge clk);
    wv[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midreset_outputs",
        32'({wr[1], hd[1], se[1], rbd[1], rbv[1], bs[1], dn[1]}), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // randomized loads on both chains
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 2; i++) begin
        for (int w = 0; w < 4; w++) wl[w] = 8'($urandom);
        do_load(i, i + 1, int'($urandom_range(0, 3)),
                bit'($urandom_range(0, 1)), 12'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
